// File: rtl/dec_key_schedule.sv
// AES-128 key schedule for the decryption datapath.
// Expands a cipher key into an 11-entry round-key bank at one key per clock.
// A registered random-access port then serves the keys; the round controller
// walks it from index 10 down to 0.
//
// Handshake: key_load is a one-cycle request. It is accepted only while busy is
// low, on the edge that samples it; when busy is high it is dropped, not queued.
// busy is high from the accept edge until the tenth key is written. keys_valid
// is the valid flag for the read port: while it is high, round_key holds the
// key for the rd_idx presented one cycle earlier. It falls on the accept edge.
module dec_key_schedule (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_load,
    input  logic [127:0] key_in,
    input  logic [3:0]   rd_idx,
    output logic [127:0] round_key,
    output logic         busy,
    output logic         keys_valid,
    output logic [1:0]   state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXPAND = 2'd1,
        S_READY  = 2'd2
    } state_t;

    // Forward AES S-box. Byte 0x00 sits in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        // Entry b lives at bit offset (255 - b) * 8; ~b equals 255 - b.
        sbox = SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    state_t       state;
    logic [3:0]   cnt;
    logic [127:0] prev;
    logic [127:0] bank [0:10];

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  rot_w3, sub_w3;
    logic [31:0]  w0_n, w1_n, w2_n, w3_n;
    logic [127:0] next_key;

    assign state_dbg = state;

    // One round of the schedule, computed from the previous round key.
    assign w0     = prev[127:96];
    assign w1     = prev[95:64];
    assign w2     = prev[63:32];
    assign w3     = prev[31:0];
    assign rot_w3 = {w3[23:0], w3[31:24]};
    assign sub_w3 = {sbox(rot_w3[31:24]), sbox(rot_w3[23:16]),
                     sbox(rot_w3[15:8]),  sbox(rot_w3[7:0])};
    assign w0_n   = w0 ^ sub_w3 ^ {rcon(cnt), 24'h0};
    assign w1_n   = w1 ^ w0_n;
    assign w2_n   = w2 ^ w1_n;
    assign w3_n   = w3 ^ w2_n;
    assign next_key = {w0_n, w1_n, w2_n, w3_n};

    // Control FSM, expansion writes and registered read port. The read samples
    // the bank before this edge's write, so a read during rekey sees the old key.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            prev       <= '0;
            round_key  <= '0;
            busy       <= 1'b0;
            keys_valid <= 1'b0;
            for (int i = 0; i <= 10; i++) begin
                bank[i] <= '0;
            end
        end else begin
            round_key <= (rd_idx <= 4'd10) ? bank[rd_idx] : '0;
            case (state)
                S_IDLE, S_READY: begin
                    if (key_load) begin
                        bank[0]    <= key_in;
                        prev       <= key_in;
                        cnt        <= 4'd1;
                        keys_valid <= 1'b0;
                        busy       <= 1'b1;
                        state      <= S_EXPAND;
                    end
                end
                S_EXPAND: begin
                    bank[cnt] <= next_key;
                    prev      <= next_key;
                    if (cnt == 4'd10) begin
                        state      <= S_READY;
                        busy       <= 1'b0;
                        keys_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dec_key_schedule.sv
// Testbench for dec_key_schedule. It uses directed FIPS-197 scenarios plus
// random keys and reads. A reference key expansion is built from GF(2^8)
// arithmetic and the textbook word recurrence, and it predicts every cycle.
module tb_dec_key_schedule;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_K10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_load;
    logic [127:0] key_in;
    logic [3:0]   rd_idx;
    logic [127:0] round_key;
    logic         busy;
    logic         keys_valid;
    logic [1:0]   state_dbg;

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    dec_key_schedule dut (
        .clk        (clk),
        .rst        (rst),
        .key_load   (key_load),
        .key_in     (key_in),
        .rd_idx     (rd_idx),
        .round_key  (round_key),
        .busy       (busy),
        .keys_valid (keys_valid),
        .state_dbg  (state_dbg)
    );

    // ---------------- reference model ----------------
    logic [7:0]   sb_tab [256];
    logic [127:0] ref_keys [11];
    logic [127:0] m_bank [11];
    int           m_phase;     // 0 idle, 1 expanding, 2 ready
    int           m_next;      // next bank entry to fill while expanding
    logic         m_busy;
    logic         m_valid;
    logic [127:0] exp_q [$];

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = xtime(x);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d = {b, b};
        return d[15 - n -: 8];
    endfunction

    // S-box = affine transform of the multiplicative inverse (a^254).
    task automatic build_sbox();
        for (int v = 0; v < 256; v++) begin
            logic [7:0] a = 8'(v);
            logic [7:0] inv = 8'h01;
            if (v == 0) inv = 8'h00;
            else for (int k = 0; k < 254; k++) inv = gmul(inv, a);
            sb_tab[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Textbook 44-word expansion, grouped four words per round key.
    task automatic expand_ref(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb_tab[t[31:24]], sb_tab[t[23:16]], sb_tab[t[15:8]], sb_tab[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) ref_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic model_reset();
        for (int i = 0; i < 11; i++) m_bank[i] = '0;
        m_phase = 0;
        m_next  = 0;
        m_busy  = 1'b0;
        m_valid = 1'b0;
        exp_q.delete();
    endtask

    // Advance the model by one clock edge given the inputs sampled at it.
    task automatic model_step(input logic ld, input logic [127:0] k, input logic [3:0] idx);
        exp_q.push_back((idx <= 4'd10) ? m_bank[idx] : 128'h0);
        if (m_phase != 1 && ld) begin
            expand_ref(k);
            m_bank[0] = k;
            m_next    = 1;
            m_phase   = 1;
            m_busy    = 1'b1;
            m_valid   = 1'b0;
        end else if (m_phase == 1) begin
            m_bank[m_next] = ref_keys[m_next];
            if (m_next == 10) begin
                m_phase = 2;
                m_busy  = 1'b0;
                m_valid = 1'b1;
            end else begin
                m_next++;
            end
        end
    endtask

    // ---------------- scoreboard check ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called just after a falling edge: drive inputs, let one rising edge pass,
    // then check outputs at the following falling edge.
    task automatic cycle(input logic ld, input logic [127:0] k, input logic [3:0] idx);
        key_load = ld;
        key_in   = k;
        rd_idx   = idx;
        model_step(ld, k, idx);
        @(negedge clk);
        check("round_key", round_key, exp_q.pop_front());
        check("busy", {127'h0, busy}, {127'h0, m_busy});
        check("keys_valid", {127'h0, keys_valid}, {127'h0, m_valid});
        key_load = 1'b0;
    endtask

    task automatic read_const(input logic [3:0] idx, input logic [127:0] want, input string tag);
        cycle(1'b0, '0, idx);
        check(tag, round_key, want);
    endtask

    // Mid-cycle asynchronous reset; outputs must clear without a clock edge.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_round_key", round_key, 128'h0);
        check("rst_busy", {127'h0, busy}, 128'h0);
        check("rst_keys_valid", {127'h0, keys_valid}, 128'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_fips_expansion(input string tag);
        int busy_cycles = 0;
        cycle(1'b1, FIPS_KEY, 4'd0);
        if (busy) busy_cycles++;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, '0, 4'(i));
            if (busy) busy_cycles++;
        end
        check({tag, "_busy_cycles"}, 128'(busy_cycles), 128'd10);
        check({tag, "_valid"}, {127'h0, keys_valid}, 128'h1);
        read_const(4'd1, FIPS_K1, {tag, "_k1"});
        read_const(4'd10, FIPS_K10, {tag, "_k10"});
        read_const(4'd0, FIPS_KEY, {tag, "_k0"});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst      = 1'b1;
        key_load = 1'b0;
        key_in   = '0;
        rd_idx   = '0;
        build_sbox();
        model_reset();
        repeat (2) @(negedge clk);
        check("por_round_key", round_key, 128'h0);
        check("por_busy", {127'h0, busy}, 128'h0);
        rst = 1'b0;

        // Reset: mid-cycle assertion, then every index reads zero.
        do_reset();
        for (int i = 0; i < 16; i++) cycle(1'b0, '0, 4'(i));

        // FIPS-197 expansion.
        run_fips_expansion("fips");

        // Decrypt-order streaming, one index per cycle.
        for (int i = 10; i >= 0; i--) read_const(4'(i), ref_keys[i], "stream");

        // Load pulsed with another key at E5 is ignored.
        cycle(1'b1, FIPS_KEY, 4'd0);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 4'd3);
        cycle(1'b1, 128'hdeadbeef_01234567_89abcdef_cafef00d, 4'd4);
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 4'd5);
        check("ignored_valid", {127'h0, keys_valid}, 128'h1);
        read_const(4'd10, FIPS_K10, "ignored_k10");
        read_const(4'd11, 128'h0, "oob_11");
        read_const(4'd15, 128'h0, "oob_15");

        // Rekey from READY with the all-zero key; same-cycle read sees old key.
        cycle(1'b1, 128'h0, 4'd10);
        check("rekey_old_read", round_key, FIPS_K10);
        check("rekey_valid_drop", {127'h0, keys_valid}, 128'h0);
        for (int i = 0; i < 10; i++) cycle(1'b0, '0, 4'd0);
        read_const(4'd10, ZERO_K10, "zero_k10");

        // Abort by reset before E4, then a clean FIPS reload.
        cycle(1'b1, 128'h0f0e0d0c_0b0a0908_07060504_03020100, 4'd0);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 4'd1);
        do_reset();
        check("abort_valid", {127'h0, keys_valid}, 128'h0);
        run_fips_expansion("abort");

        // Random keys, random reads, random (often ignored) load pulses.
        for (int r = 0; r < 8; r++) begin
            cycle(1'b1, {$urandom, $urandom, $urandom, $urandom}, 4'($urandom_range(0, 15)));
            for (int c = 0; c < 30; c++) begin
                cycle(($urandom_range(0, 19) == 0), {$urandom, $urandom, $urandom, $urandom},
                      4'($urandom_range(0, 15)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dec_key_schedule.md
# dec_key_schedule

Upstream key source for the AES-128 decryption datapath. It accepts a 128-bit cipher key and expands it iteratively, one round key per clock, into an 11-entry key bank. It then serves any round key through a registered random-access read port. The round controller reads keys 10 down to 0 and drives each one onto the `round_key` input of the decryption round stage.

## Interface
- Parameters: none; AES-128 only (Nr = 10, 11 round keys).
- `clk` — in, 1 — single clock; all state updates on its rising edge.
- `rst` — in, 1 — reset is asynchronous and active-high.
- `key_load` — in, 1 — start-expansion strobe; sampled only in IDLE or READY.
- `key_in` — in, 128 — cipher key; byte 0 on `[127:120]` (FIPS-197 order); sampled with `key_load`.
- `rd_idx` — in, 4 — encryption-round number of the key to read (0..10).
- `round_key` — out, 128 — registered read data for `rd_idx`.
- `busy` — out, 1 — expansion in progress.
- `keys_valid` — out, 1 — all 11 keys present and consistent with the last loaded key.

## Operation
- **FSM states:** IDLE, EXPAND, READY.
  - IDLE + `key_load` → EXPAND.
  - EXPAND with count = 10 → READY.
  - READY + `key_load` → EXPAND (rekey).
  - `key_load` during EXPAND is ignored: no restart, no queueing.
- **Load edge:**
  - `bank[0] <= key_in`
  - `prev <= key_in`
  - `cnt <= 1`
  - `keys_valid <= 0`
- **Each EXPAND edge:**
  - `w0' = w0 ^ SubWord(RotWord(w3)) ^ {Rcon[cnt], 24'h0}`
  - `w1' = w1 ^ w0'`
  - `w2' = w2 ^ w1'`
  - `w3' = w3 ^ w2'`
  - `w0` = `prev[127:96]`, `w3` = `prev[31:0]`.
  - Writes: `bank[cnt] <= {w0',w1',w2',w3'}`, `prev <= {w0',w1',w2',w3'}`, `cnt <= cnt+1`.
- **Rcon[1..10]:** 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
- **SubWord:** four forward S-box instances, combinational.
- **Read port:** `round_key <= (rd_idx <= 10) ? bank[rd_idx] : 128'h0`.
  - Updates every cycle in every state.
  - During EXPAND it returns whatever the bank currently holds: stale or partially new. Consumers must gate reads on `keys_valid`.
- **`cnt`:** 4 bits; never exceeds 10; no wrap.

## Timing
- **Reset values (asynchronous):** state IDLE, `cnt` 0, `prev` 0, all bank entries 0, `round_key` 0, `busy` 0, `keys_valid` 0.
- **Expansion sequence:** call the edge that samples `key_load` E0.
  - Bank entry `i` is written at edge Ei, for i = 1..10.
  - At E10: state → READY, `busy` → 0, `keys_valid` → 1.
  - `busy` is high from after E0 through E10.
  - Expansion latency is 10 cycles; the first valid `round_key` read data appears one cycle after that.
- **Read latency:** 1 cycle. A `rd_idx` change at edge N is reflected on `round_key` after edge N+1. A different index may be presented every cycle.
- **Rekey in READY:** `keys_valid` drops at the load edge. A read issued in that same cycle returns the old key, because the bank is read before the write.
- **`rst` during EXPAND:** aborts immediately to reset values; no partial `keys_valid`.
- **`key_load` and `rst` together:** reset wins.

## Test plan
- **Reset:** assert `rst` mid-cycle → `round_key`, `busy`, `keys_valid` all 0 immediately; every `rd_idx` read returns 0.
- **FIPS-197 key expansion:** load `2b7e151628aed2a6abf7158809cf4f3c` → `busy` for exactly 10 cycles, then `keys_valid` = 1. Then:
  - `rd_idx` = 1 → `a0fafe1788542cb123a339392a6c7605`
  - `rd_idx` = 10 → `d014f9a8c9ee2589e13f0cc8b6630ca6`
  - `rd_idx` = 0 → the cipher key
- **Decrypt-order streaming:** with `keys_valid` = 1, sweep `rd_idx` 10, 9, …, 0 one per cycle → each key appears exactly one cycle later, in order, with no bubbles.
- **Ignored load and out-of-range read:** pulse `key_load` with a different key at E5 of an expansion → ignored, and the original expansion completes unchanged. Then `rd_idx` = 11 and `rd_idx` = 15 → `round_key` = 0.
- **Rekey from READY:** load all-zero key `000…0` → `keys_valid` falls on the load edge. After 10 cycles, `rd_idx` = 10 → `b4ef5bcb3e92e21123e951cf6f8f188e`.
- **Abort by reset:** assert `rst` at E4 of an expansion, then reload the FIPS key → results are identical to the FIPS-197 expansion scenario.
